// File: rtl/belt_pkg.sv
// belt_pkg -- shared types and helpers for the seat-belt chime sequencer.
//
// Contents:
//   belt_state_t : sequencer state (IDLE, ARM, CHIME, LAMP)
//   cnt_w()      : counter width for a counter that must hold values 0..v-1
//                  with one spare bit ($clog2(v)+1), so compares never wrap.
package belt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHIME = 2'd2,
    LAMP  = 2'd3
  } belt_state_t;

  function automatic int cnt_w(input int v);
    return $clog2(v) + 1;
  endfunction

endpackage

// File: rtl/belt_tick_gen.sv
// belt_tick_gen -- timebase prescaler for the seat-belt chime sequencer.
//
// Counts 0..TICK_DIV-1 and flags the cycle where the count sits at its last
// value. Clearing restarts the count from 0 on the next edge.
//
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  synchronous active-low reset
//   clear in  synchronous clear of the prescaler
//   tick  out high for the one cycle where prescaler = TICK_DIV-1
module belt_tick_gen
  import belt_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pre <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // With TICK_DIV = 1 the prescaler is stuck at 0, so every cycle is a tick.
  assign tick = (pre == PRE_LAST);

endmodule

// File: rtl/belt_chime_ctrl.sv
// belt_chime_ctrl -- seat-belt warning sequencer.
//
// Turns the unbuckled-warning level into driver alerts: an arming delay,
// a chime burst with a blinking lamp, then a steady lamp. Dropping warn_in
// returns to IDLE immediately (outputs 0 on the edge that samples it low);
// re-raising it always restarts the full arming delay.
//
// Optional feature macro: BELT_SNOOZE_EN -- adds the snooze input; a snooze
// sampled high in CHIME skips straight to the steady lamp.
//
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  synchronous active-low reset
//   warn_in in  unbuckled-warning level (clk-synchronous)
//   snooze  in  driver acknowledge pulse (BELT_SNOOZE_EN builds only)
//   chime   out audible alert enable, registered
//   lamp    out belt lamp drive, registered
//   active  out high whenever the sequencer is not idle, registered
//
// Handshake: none; warn_in is a level, snooze a single-cycle pulse, both
// sampled on every rising edge.
module belt_chime_ctrl
  import belt_pkg::*;
#(
  parameter int TICK_DIV    = 4,
  parameter int ARM_TICKS   = 3,
  parameter int CHIME_TICKS = 4,
  parameter int BLINK_TICKS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic warn_in,
`ifdef BELT_SNOOZE_EN
  input  logic snooze,
`endif
  output logic chime,
  output logic lamp,
  output logic active
);

  localparam int TW = cnt_w((ARM_TICKS > CHIME_TICKS) ? ARM_TICKS : CHIME_TICKS);
  localparam int BW = cnt_w(BLINK_TICKS);
  localparam logic [TW-1:0] ARM_LAST   = TW'(ARM_TICKS - 1);
  localparam logic [TW-1:0] CHIME_LAST = TW'(CHIME_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  belt_state_t   state;
  belt_state_t   state_nxt;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;
  logic          tick;
  logic          clear;
  logic          blink_flip;
  logic          snooze_hit;

`ifdef BELT_SNOOZE_EN
  assign snooze_hit = snooze;
`else
  assign snooze_hit = 1'b0;
`endif

  // Timebase restarts on every state change and stays parked while idle.
  assign clear = (state_nxt != state) || (state == IDLE);

  belt_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  // Lamp flips on every BLINK_TICKS-th tick of the chime burst.
  assign blink_flip = (state == CHIME) && tick && (blink_cnt == BLINK_LAST);

  // Next-state decode; a low warn_in beats any tick or snooze event.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (warn_in) state_nxt = ARM;
      end
      ARM: begin
        if (!warn_in) state_nxt = IDLE;
        else if (tick && (tick_cnt == ARM_LAST)) state_nxt = CHIME;
      end
      CHIME: begin
        if (!warn_in) state_nxt = IDLE;
        else if (snooze_hit || (tick && (tick_cnt == CHIME_LAST))) state_nxt = LAMP;
      end
      LAMP: begin
        if (!warn_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and outputs share one register stage so the outputs
  // move on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      blink_cnt <= '0;
      chime     <= 1'b0;
      lamp      <= 1'b0;
      active    <= 1'b0;
    end else begin
      state <= state_nxt;

      // Only ARM and CHIME measure durations; LAMP holds the count so it
      // cannot run past its width.
      if (clear) begin
        tick_cnt <= '0;
      end else if (tick && ((state == ARM) || (state == CHIME))) begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (clear) begin
        blink_cnt <= '0;
      end else if ((state == CHIME) && tick) begin
        blink_cnt <= blink_flip ? '0 : blink_cnt + 1'b1;
      end

      active <= (state_nxt != IDLE);
      chime  <= (state_nxt == CHIME);
      case (state_nxt)
        LAMP:    lamp <= 1'b1;
        CHIME:   lamp <= (state != CHIME) ? 1'b1 : (lamp ^ blink_flip);
        default: lamp <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_belt_chime_ctrl.sv
// tb_belt_chime_ctrl -- bench for belt_chime_ctrl.
//
// Three instances with different timing parameters share one stimulus
// stream. The reference model describes each instance by the age (in edges)
// of the current warning episode and derives outputs from the timing rules.
module tb_belt_chime_ctrl;

  localparam int TD_A = 4, ARM_A = 3, CHM_A = 4, BLK_A = 1;
  localparam int TD_B = 1, ARM_B = 1, CHM_B = 5, BLK_B = 1;
  localparam int TD_C = 2, ARM_C = 2, CHM_C = 6, BLK_C = 2;

`ifdef BELT_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       warn_in = 1'b0;
  logic       snooze = 1'b0;
  logic [2:0] chime_v;
  logic [2:0] lamp_v;
  logic [2:0] active_v;

  always #5 clk = ~clk;

  belt_chime_ctrl #(.TICK_DIV(TD_A), .ARM_TICKS(ARM_A), .CHIME_TICKS(CHM_A), .BLINK_TICKS(BLK_A)) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .warn_in (warn_in),
`ifdef BELT_SNOOZE_EN
    .snooze  (snooze),
`endif
    .chime   (chime_v[0]),
    .lamp    (lamp_v[0]),
    .active  (active_v[0])
  );

  belt_chime_ctrl #(.TICK_DIV(TD_B), .ARM_TICKS(ARM_B), .CHIME_TICKS(CHM_B), .BLINK_TICKS(BLK_B)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .warn_in (warn_in),
`ifdef BELT_SNOOZE_EN
    .snooze  (snooze),
`endif
    .chime   (chime_v[1]),
    .lamp    (lamp_v[1]),
    .active  (active_v[1])
  );

  belt_chime_ctrl #(.TICK_DIV(TD_C), .ARM_TICKS(ARM_C), .CHIME_TICKS(CHM_C), .BLINK_TICKS(BLK_C)) u_dut_c (
    .clk     (clk),
    .rst_n   (rst_n),
    .warn_in (warn_in),
`ifdef BELT_SNOOZE_EN
    .snooze  (snooze),
`endif
    .chime   (chime_v[2]),
    .lamp    (lamp_v[2]),
    .active  (active_v[2])
  );

  // ---------------- reference model ----------------
  int td_p[3]  = '{TD_A, TD_B, TD_C};
  int arm_p[3] = '{ARM_A, ARM_B, ARM_C};
  int chm_p[3] = '{CHM_A, CHM_B, CHM_C};
  int blk_p[3] = '{BLK_A, BLK_B, BLK_C};
  int age[3]   = '{-1, -1, -1};   // edges since warning episode began; -1 = idle
  bit snz[3]   = '{1'b0, 1'b0, 1'b0};

  // Returns {chime, lamp, active} for the current model age.
  function automatic logic [2:0] model_out(input int i);
    int a_len, c_len, b_len;
    a_len = arm_p[i] * td_p[i];
    c_len = chm_p[i] * td_p[i];
    b_len = blk_p[i] * td_p[i];
    if (age[i] < 0) return 3'b000;
    if (age[i] < a_len) return 3'b001;
    if ((age[i] < a_len + c_len) && !snz[i])
      return {1'b1, (((age[i] - a_len) / b_len) % 2) == 0, 1'b1};
    return 3'b011;
  endfunction

  function automatic void model_step(input int i, input logic w, input logic r, input logic s);
    int a_len, c_len;
    a_len = arm_p[i] * td_p[i];
    c_len = chm_p[i] * td_p[i];
    if (!r || !w) begin
      age[i] = -1;
      snz[i] = 1'b0;
    end else if (age[i] < 0) begin
      age[i] = 0;
      snz[i] = 1'b0;
    end else begin
      if (SNZ_EN && s && (age[i] >= a_len) && (age[i] < a_len + c_len)) snz[i] = 1'b1;
      age[i] = age[i] + 1;
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic w, input logic r, input logic s);
    logic [2:0] e;
    warn_in = w;
    rst_n   = r;
    snooze  = s;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      model_step(i, w, r, s);
      exp_q.push_back(model_out(i));
    end
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      check($sformatf("dut%0d.chime", i),  chime_v[i],  e[2]);
      check($sformatf("dut%0d.lamp", i),   lamp_v[i],   e[1]);
      check($sformatf("dut%0d.active", i), active_v[i], e[0]);
    end
  endtask

  task automatic hold(input logic w, input int n);
    for (int k = 0; k < n; k++) step(w, 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi_len;
    int lo_len;

    // Reset state.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    hold(1'b0, 2);

    // Warning held through the whole sequence into steady lamp.
    hold(1'b1, 34);
    hold(1'b0, 3);

    // Warning too short to reach the chime.
    hold(1'b1, 11);
    hold(1'b0, 3);

    // Drop mid-chime at E18, re-raise at E20.
    hold(1'b1, 18);
    hold(1'b0, 2);
    hold(1'b1, 36);
    hold(1'b0, 2);

    // One-cycle reset at E15 with warning held.
    hold(1'b1, 15);
    step(1'b1, 1'b0, 1'b0);
    hold(1'b1, 30);
    hold(1'b0, 2);

    // Snooze at E14 (acts only in snooze builds).
    hold(1'b1, 14);
    step(1'b1, 1'b1, 1'b1);
    hold(1'b1, 20);
    hold(1'b0, 2);

    // Snooze and warning drop on the same edge.
    hold(1'b1, 14);
    step(1'b0, 1'b1, 1'b1);
    hold(1'b0, 2);

    // Randomized episodes with sporadic snooze and reset.
    for (int ep = 0; ep < 60; ep++) begin
      hi_len = $urandom_range(1, 45);
      lo_len = $urandom_range(1, 4);
      for (int k = 0; k < hi_len; k++)
        step(1'b1, ($urandom_range(0, 99) != 0), ($urandom_range(0, 11) == 0));
      for (int k = 0; k < lo_len; k++)
        step(1'b0, 1'b1, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
